key_debounce: RTL and testbench

//  Consumes the keypad row-scanner outputs (press, 4-bit key code). Because the

---
 rtl/key_debounce.sv | 151 +++++++++++++++
 tb/tb_key_debounce.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Keypad debouncer: qualifies a key after DEBOUNCE_HITS consistent scanner sightings,
// emits a one-cycle key_valid pulse, and tracks hold/release of the accepted key.
module key_debounce #(
  parameter int DEBOUNCE_HITS  = 16,
  parameter int SCAN_PERIOD    = 4,
  parameter int RELEASE_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       press,
  input  logic [3:0] key_code,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic       key_held
);

  localparam int HIT_W = $clog2(DEBOUNCE_HITS + 1);
  localparam int GAP_W = $clog2(SCAN_PERIOD + 1);
  localparam int IDL_W = $clog2(RELEASE_CYCLES + 1);

  localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(DEBOUNCE_HITS);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SCAN_PERIOD);
  localparam logic [IDL_W-1:0] IDL_MAX = IDL_W'(RELEASE_CYCLES);
  localparam logic [3:0]       NO_KEY  = 4'hD;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    HELD   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       cand, cand_nxt;
  logic [HIT_W-1:0] hit_cnt, hit_cnt_nxt;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
  logic [IDL_W-1:0] idle_cnt, idle_cnt_nxt;
  logic             key_valid_nxt;
  logic [3:0]       key_value_nxt;
  logic             key_held_nxt;
  logic             hit;

  // Saturating increments: counters stop at their terminal value instead of wrapping.
  function automatic logic [HIT_W-1:0] inc_hit(input logic [HIT_W-1:0] v);
    return (v == HIT_MAX) ? v : v + HIT_W'(1);
  endfunction

  function automatic logic [GAP_W-1:0] inc_gap(input logic [GAP_W-1:0] v);
    return (v == GAP_MAX) ? v : v + GAP_W'(1);
  endfunction

  function automatic logic [IDL_W-1:0] inc_idle(input logic [IDL_W-1:0] v);
    return (v == IDL_MAX) ? v : v + IDL_W'(1);
  endfunction

  // Codes 12..15 never count as a sighting, even with press high.
  assign hit = press && (key_code <= 4'd11);

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    hit_cnt_nxt   = hit_cnt;
    gap_cnt_nxt   = gap_cnt;
    idle_cnt_nxt  = idle_cnt;
    key_valid_nxt = 1'b0;
    key_value_nxt = key_value;
    key_held_nxt  = key_held;

    case (state)
      IDLE: begin
        hit_cnt_nxt  = '0;
        gap_cnt_nxt  = '0;
        idle_cnt_nxt = '0;
        key_held_nxt = 1'b0;
        if (hit) begin
          cand_nxt    = key_code;
          hit_cnt_nxt = HIT_W'(1);
          state_nxt   = ARMING;
        end
      end

      ARMING: begin
        if (hit && (key_code == cand)) begin
          gap_cnt_nxt = '0;
          hit_cnt_nxt = inc_hit(hit_cnt);
          if (inc_hit(hit_cnt) == HIT_MAX) begin
            state_nxt     = HELD;
            key_value_nxt = cand;
            key_valid_nxt = 1'b1;
            key_held_nxt  = 1'b1;
            idle_cnt_nxt  = '0;
          end
        end else if (hit) begin
          cand_nxt    = key_code;
          hit_cnt_nxt = HIT_W'(1);
          gap_cnt_nxt = '0;
        end else begin
          gap_cnt_nxt = inc_gap(gap_cnt);
          // A full scan frame without a sighting means the key was let go.
          if (inc_gap(gap_cnt) == GAP_MAX) begin
            state_nxt   = IDLE;
            hit_cnt_nxt = '0;
            gap_cnt_nxt = '0;
          end
        end
      end

      HELD: begin
        // Any sighting, even of another key, keeps the accepted key alive.
        if (hit) begin
          idle_cnt_nxt = '0;
        end else begin
          idle_cnt_nxt = inc_idle(idle_cnt);
          if (inc_idle(idle_cnt) == IDL_MAX) begin
            state_nxt    = IDLE;
            key_held_nxt = 1'b0;
            hit_cnt_nxt  = '0;
            gap_cnt_nxt  = '0;
            idle_cnt_nxt = '0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cand      <= NO_KEY;
      hit_cnt   <= '0;
      gap_cnt   <= '0;
      idle_cnt  <= '0;
      key_valid <= 1'b0;
      key_value <= NO_KEY;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cand      <= cand_nxt;
      hit_cnt   <= hit_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      idle_cnt  <= idle_cnt_nxt;
      key_valid <= key_valid_nxt;
      key_value <= key_value_nxt;
      key_held  <= key_held_nxt;
    end
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random scanner traffic, checked
// cycle by cycle against a sighting-history reference model.
module tb_key_debounce;

  localparam int DH = 4;
  localparam int SP = 4;
  localparam int RC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       press;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] key_value;
  logic       key_held;

  key_debounce #(
    .DEBOUNCE_HITS (DH),
    .SCAN_PERIOD   (SP),
    .RELEASE_CYCLES(RC)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .press    (press),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_value(key_value),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    pulses = 0;
  int    pulses_mark;
  string phase = "reset";

  // Reference model: held flag, current sighting run, and no-hit streak since last hit.
  logic       exp_valid;
  logic [3:0] exp_value;
  logic       exp_held;
  logic [3:0] run_code;
  int         run_len;
  int         quiet;

  task automatic model_reset();
    exp_valid = 1'b0;
    exp_value = 4'hD;
    exp_held  = 1'b0;
    run_code  = 4'hD;
    run_len   = 0;
    quiet     = 0;
  endtask

  task automatic model_step(input logic p, input logic [3:0] c);
    bit h;
    h = p && (c <= 4'd11);
    exp_valid = 1'b0;
    if (h) begin
      if (!exp_held) begin
        if (run_len > 0 && quiet < SP && c == run_code) run_len++;
        else begin
          run_code = c;
          run_len  = 1;
        end
        if (run_len == DH) begin
          exp_valid = 1'b1;
          exp_value = c;
          exp_held  = 1'b1;
          run_len   = 0;
        end
      end
      quiet = 0;
    end else begin
      quiet++;
      if (exp_held && quiet == RC) exp_held = 1'b0;
    end
  endtask

  task automatic chk(input string field, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s_%s got=%0h exp=%0h", phase, field, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("valid", {3'b000, key_valid}, {3'b000, exp_valid});
    chk("value", key_value, exp_value);
    chk("held",  {3'b000, key_held},  {3'b000, exp_held});
  endtask

  task automatic step(input logic p, input logic [3:0] c);
    press    = p;
    key_code = c;
    @(posedge clk);
    model_step(p, c);
    #1;
    if (key_valid === 1'b1) pulses++;
    chk_outputs();
  endtask

  task automatic idle_n(input int n);
    repeat (n) step(1'b0, 4'hD);
  endtask

  // One sighting of a key followed by the rest of its scan frame.
  task automatic hit_key(input logic [3:0] c);
    step(1'b1, c);
    idle_n(SP - 1);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    chk_outputs();
    @(posedge clk);
    #1;
    chk_outputs();
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    press    = 1'b0;
    key_code = 4'hD;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_outputs();
    reset = 1'b0;

    // Short run then a full frame of silence: no acceptance.
    phase = "abort";
    step(1'b1, 4'd5); idle_n(SP - 1);
    step(1'b1, 4'd5); idle_n(SP);
    idle_n(4);
    chk("pulses", 4'(pulses), 4'd0);
    chk("value_d", key_value, 4'hD);

    // Candidate switches mid-run: only the later key is accepted.
    phase = "switch";
    hit_key(4'd5); hit_key(4'd5);
    hit_key(4'd7); hit_key(4'd7); hit_key(4'd7);
    step(1'b1, 4'd7);
    chk("pulse7", {3'b000, key_valid}, 4'd1);
    chk("value7", key_value, 4'd7);
    idle_n(RC + 2);

    // Clean acceptance of key 5, then held for several frames.
    phase = "accept";
    pulses_mark = pulses;
    repeat (DH) hit_key(4'd5);
    repeat (6) hit_key(4'd5);
    hit_key(4'd9);
    chk("one_pulse", 4'(pulses - pulses_mark), 4'd1);
    chk("held5", {3'b000, key_held}, 4'd1);

    // Release keeps key_value, then a fresh key 0 is accepted.
    phase = "release";
    idle_n(RC);
    chk("released", {3'b000, key_held}, 4'd0);
    chk("kept5", key_value, 4'd5);
    repeat (DH) hit_key(4'd0);
    chk("value0", key_value, 4'd0);
    idle_n(RC + 1);

    // Press with out-of-range codes is ignored.
    phase = "badcode";
    pulses_mark = pulses;
    for (int i = 0; i < 50; i++) step(1'b1, (i % 2 == 0) ? 4'd13 : 4'd14);
    step(1'b1, 4'd12); step(1'b1, 4'd15);
    idle_n(SP);
    chk("no_pulse", 4'(pulses - pulses_mark), 4'd0);

    // Asynchronous reset while arming and while held.
    phase = "rst_arm";
    repeat (DH - 1) hit_key(4'd3);
    async_reset();
    phase = "rst_held";
    repeat (DH) hit_key(4'd2);
    async_reset();
    phase = "post_rst";
    pulses_mark = pulses;
    repeat (DH - 1) hit_key(4'd3);
    idle_n(SP + 2);
    chk("no_pulse", 4'(pulses - pulses_mark), 4'd0);

    // Random scanner traffic.
    phase = "random";
    begin
      logic [3:0] cur_key;
      logic [3:0] code;
      logic       p;
      cur_key = 4'(($urandom_range(0, 11)));
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(0, 119) == 0) cur_key = 4'($urandom_range(0, 11));
        p    = ($urandom_range(0, 99) < 30);
        code = ($urandom_range(0, 9) < 8) ? cur_key : 4'($urandom_range(0, 15));
        if ($urandom_range(0, 499) == 0) async_reset();
        else step(p, code);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
